// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: write-back source select and load funct3 encodings.
package rv32i_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2,
        WB_IMM  = 2'd3
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// Combinational load aligner: picks the addressed byte/halfword from an aligned
// memory word and sign- or zero-extends it according to funct3.
module load_align
    import rv32i_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] i_word,
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_offset,
    output logic [XLEN-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_offset)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        // Halfword loads ignore offset bit 0; misalignment is trapped elsewhere.
        w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];
    end

    always_comb begin
        o_data = i_word;
        case (i_funct3)
            F3_LB:   o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            F3_LBU:  o_data = {{(XLEN-8){1'b0}}, w_byte};
            F3_LH:   o_data = {{(XLEN-16){w_half[15]}}, w_half};
            F3_LHU:  o_data = {{(XLEN-16){1'b0}}, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register, write-back source mux and retired-instruction counter.
// All outputs derive from registered state only.
module writeback_stage
    import rv32i_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned SELECTORS = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall_i,
    input  logic                 flush_i,
    input  logic                 mem_valid_i,
    input  logic                 mem_reg_wen_i,
    input  logic [SELECTORS-1:0] mem_rd_addr_i,
    input  logic [1:0]           mem_wb_sel_i,
    input  logic [XLEN-1:0]      mem_alu_result_i,
    input  logic [XLEN-1:0]      mem_pc_plus4_i,
    input  logic [XLEN-1:0]      mem_imm_i,
    input  logic [XLEN-1:0]      mem_load_word_i,
    input  logic [2:0]           mem_funct3_i,
    output logic [SELECTORS-1:0] rsW,
    output logic [XLEN-1:0]      rd,
    output logic                 RegWEn,
    output logic                 wb_valid_o,
    output logic [63:0]          instret_o
);

    logic                 r_valid;
    logic                 r_reg_wen;
    logic [SELECTORS-1:0] r_rd_addr;
    wb_sel_e              r_wb_sel;
    logic [XLEN-1:0]      r_alu_result;
    logic [XLEN-1:0]      r_pc_plus4;
    logic [XLEN-1:0]      r_imm;
    logic [XLEN-1:0]      r_load_word;
    logic [2:0]           r_funct3;
    logic [63:0]          r_instret;

    logic                 w_retire;
    logic [XLEN-1:0]      w_load_data;
    logic [XLEN-1:0]      w_rd_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_reg_wen    <= 1'b0;
            r_rd_addr    <= '0;
            r_wb_sel     <= WB_ALU;
            r_alu_result <= '0;
            r_pc_plus4   <= '0;
            r_imm        <= '0;
            r_load_word  <= '0;
            r_funct3     <= '0;
        end else if (flush_i) begin
            // Bubble: only the qualifiers are cleared, payload fields are don't-care.
            r_valid   <= 1'b0;
            r_reg_wen <= 1'b0;
        end else if (!stall_i) begin
            r_valid      <= mem_valid_i;
            r_reg_wen    <= mem_reg_wen_i;
            r_rd_addr    <= mem_rd_addr_i;
            r_wb_sel     <= wb_sel_e'(mem_wb_sel_i);
            r_alu_result <= mem_alu_result_i;
            r_pc_plus4   <= mem_pc_plus4_i;
            r_imm        <= mem_imm_i;
            r_load_word  <= mem_load_word_i;
            r_funct3     <= mem_funct3_i;
        end
    end

    // An instruction retires once, on the edge where it leaves WB.
    assign w_retire = r_valid & (~stall_i | flush_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instret <= '0;
        end else if (w_retire) begin
            r_instret <= r_instret + 64'd1;
        end
    end

    load_align #(
        .XLEN(XLEN)
    ) u_load_align (
        .i_word  (r_load_word),
        .i_funct3(r_funct3),
        .i_offset(r_alu_result[1:0]),
        .o_data  (w_load_data)
    );

    always_comb begin
        w_rd_data = r_alu_result;
        case (r_wb_sel)
            WB_ALU:  w_rd_data = r_alu_result;
            WB_LOAD: w_rd_data = w_load_data;
            WB_PC4:  w_rd_data = r_pc_plus4;
            WB_IMM:  w_rd_data = r_imm;
            default: w_rd_data = r_alu_result;
        endcase
    end

    assign rsW        = r_rd_addr;
    assign rd         = w_rd_data;
    assign RegWEn     = r_valid & r_reg_wen & (r_rd_addr != '0);
    assign wb_valid_o = r_valid;
    assign instret_o  = r_instret;

endmodule
